// File: rtl/pipe_stage_buf.sv
// ---------------------------------------------------------------------------
// pipe_stage_buf
//
// Pipeline-stage register with a two-entry skid buffer and a ready/valid
// handshake on both sides. It carries PC, instruction, delay-slot flag and
// exception code between adjacent CPU stages. Flush and exception request
// replace the buffered contents with a bubble (instr 0). The bubble carries
// PC 0 for a flush and HANDLER_PC for an exception request.
//
// Optional feature macro: PIPE_STAGE_PERF_EN
//   When defined, adds output stall_cnt[31:0]. It counts the cycles in which
//   out_valid=1 and out_ready=0. Only reset clears it, and it wraps.
//
// Ports
//   clk        in   clock
//   reset      in   synchronous, active-high reset
//   flush      in   discard entries, bubble with PC 0
//   req        in   exception request, bubble with PC HANDLER_PC (beats flush)
//   in_valid   in   upstream entry valid
//   in_ready   out  stage can accept an entry (registered, no out_ready path)
//   in_pc      in   upstream PC
//   in_instr   in   upstream instruction
//   in_bd      in   upstream delay-slot flag
//   in_exc     in   upstream exception code
//   out_valid  out  head entry valid
//   out_ready  in   downstream accepts head this cycle
//   out_pc     out  head PC (meaningful during bubbles too, e.g. handler PC)
//   out_instr  out  head instruction
//   out_bd     out  head delay-slot flag
//   out_exc    out  head exception code
//   stall_cnt  out  stall cycle counter (only with PIPE_STAGE_PERF_EN)
// ---------------------------------------------------------------------------
module pipe_stage_buf #(
    parameter int              PC_W       = 32,
    parameter int              INSTR_W    = 32,
    parameter int              EXC_W      = 5,
    parameter logic [PC_W-1:0] HANDLER_PC = 32'h0000_4180
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               req,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [PC_W-1:0]    in_pc,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic               in_bd,
    input  logic [EXC_W-1:0]   in_exc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [PC_W-1:0]    out_pc,
    output logic [INSTR_W-1:0] out_instr,
    output logic               out_bd,
    output logic [EXC_W-1:0]   out_exc
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [31:0]        stall_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t             state_q,      state_d;
    logic [PC_W-1:0]    head_pc_q,    head_pc_d;
    logic [INSTR_W-1:0] head_instr_q, head_instr_d;
    logic               head_bd_q,    head_bd_d;
    logic [EXC_W-1:0]   head_exc_q,   head_exc_d;
    logic [PC_W-1:0]    skid_pc_q,    skid_pc_d;
    logic [INSTR_W-1:0] skid_instr_q, skid_instr_d;
    logic               skid_bd_q,    skid_bd_d;
    logic [EXC_W-1:0]   skid_exc_q,   skid_exc_d;
    // Handshake flags are kept as flops decoded from the next state, so
    // in_ready never depends combinationally on out_ready.
    logic               in_ready_q,   in_ready_d;
    logic               out_valid_q,  out_valid_d;

    logic               push_s;
    logic               pop_s;

    // Handshake events as seen at the coming clock edge.
    always_comb begin
        push_s = in_valid & in_ready_q;
        pop_s  = out_valid_q & out_ready;
    end

    // Next-state and datapath selection. Priority is reset, req, flush,
    // then normal operation.
    always_comb begin
        state_d      = state_q;
        head_pc_d    = head_pc_q;
        head_instr_d = head_instr_q;
        head_bd_d    = head_bd_q;
        head_exc_d   = head_exc_q;
        skid_pc_d    = skid_pc_q;
        skid_instr_d = skid_instr_q;
        skid_bd_d    = skid_bd_q;
        skid_exc_d   = skid_exc_q;

        if (reset) begin
            state_d      = ST_EMPTY;
            head_pc_d    = '0;
            head_instr_d = '0;
            head_bd_d    = 1'b0;
            head_exc_d   = '0;
            skid_pc_d    = '0;
            skid_instr_d = '0;
            skid_bd_d    = 1'b0;
            skid_exc_d   = '0;
        end else if (req || flush) begin
            // Bubble: any same-cycle push is dropped. A same-cycle pop has
            // already been taken by the downstream stage.
            state_d      = ST_EMPTY;
            head_pc_d    = req ? HANDLER_PC : '0;
            head_instr_d = '0;
            head_bd_d    = 1'b0;
            head_exc_d   = '0;
            skid_pc_d    = '0;
            skid_instr_d = '0;
            skid_bd_d    = 1'b0;
            skid_exc_d   = '0;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (push_s) begin
                        state_d      = ST_ONE;
                        head_pc_d    = in_pc;
                        head_instr_d = in_instr;
                        head_bd_d    = in_bd;
                        head_exc_d   = in_exc;
                    end else begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (push_s && pop_s) begin
                        state_d      = ST_ONE;
                        head_pc_d    = in_pc;
                        head_instr_d = in_instr;
                        head_bd_d    = in_bd;
                        head_exc_d   = in_exc;
                    end else if (push_s) begin
                        state_d      = ST_TWO;
                        skid_pc_d    = in_pc;
                        skid_instr_d = in_instr;
                        skid_bd_d    = in_bd;
                        skid_exc_d   = in_exc;
                    end else if (pop_s) begin
                        // Drained: leave a nop bubble but keep the last PC
                        // visible to downstream.
                        state_d      = ST_EMPTY;
                        head_instr_d = '0;
                        head_bd_d    = 1'b0;
                        head_exc_d   = '0;
                    end else begin
                        state_d = ST_ONE;
                    end
                end
                ST_TWO: begin
                    // in_ready is low here, so only a pop can happen.
                    if (pop_s) begin
                        state_d      = ST_ONE;
                        head_pc_d    = skid_pc_q;
                        head_instr_d = skid_instr_q;
                        head_bd_d    = skid_bd_q;
                        head_exc_d   = skid_exc_q;
                    end else begin
                        state_d = ST_TWO;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end

        in_ready_d  = (state_d != ST_TWO);
        out_valid_d = (state_d != ST_EMPTY);
    end

    // Stage registers. Reset is folded into the _d logic because it is
    // synchronous.
    always_ff @(posedge clk) begin
        state_q      <= state_d;
        head_pc_q    <= head_pc_d;
        head_instr_q <= head_instr_d;
        head_bd_q    <= head_bd_d;
        head_exc_q   <= head_exc_d;
        skid_pc_q    <= skid_pc_d;
        skid_instr_q <= skid_instr_d;
        skid_bd_q    <= skid_bd_d;
        skid_exc_q   <= skid_exc_d;
        in_ready_q   <= in_ready_d;
        out_valid_q  <= out_valid_d;
    end

    // Output mapping straight from flops.
    always_comb begin
        in_ready  = in_ready_q;
        out_valid = out_valid_q;
        out_pc    = head_pc_q;
        out_instr = head_instr_q;
        out_bd    = head_bd_q;
        out_exc   = head_exc_q;
    end

`ifdef PIPE_STAGE_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // Stall counter: req/flush do not clear it, and it wraps naturally.
    always_comb begin
        if (reset) begin
            stall_cnt_d = 32'd0;
        end else if (out_valid_q && !out_ready) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk) begin
        stall_cnt_q <= stall_cnt_d;
    end

    // Counter output from flop.
    always_comb begin
        stall_cnt = stall_cnt_q;
    end
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
module tb_pipe_stage_buf;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        req = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_pc = 32'd0;
    logic [31:0] in_instr = 32'd0;
    logic        in_bd = 1'b0;
    logic [4:0]  in_exc = 5'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        out_bd;
    logic [4:0]  out_exc;
`ifdef PIPE_STAGE_PERF_EN
    logic [31:0] stall_cnt;
`endif

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        bd;
        logic [4:0]  exc;
        int          due;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    pipe_stage_buf dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .req       (req),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pc     (in_pc),
        .in_instr  (in_instr),
        .in_bd     (in_bd),
        .in_exc    (in_exc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .out_instr (out_instr),
        .out_bd    (out_bd),
        .out_exc   (out_exc)
`ifdef PIPE_STAGE_PERF_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every accepted head must match the oldest expected entry.
    always @(negedge clk) begin
        if (!reset && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_pop", {64'd0, out_pc}, 96'd0 - 96'd1);
            end else begin
                mon_e = exp_q.pop_front();
                chk("pop_data", {26'd0, out_pc, out_instr, out_bd, out_exc},
                    {26'd0, mon_e.pc, mon_e.instr, mon_e.bd, mon_e.exc});
                if (mon_e.due >= 0) chk("latency", 96'(cyc), 96'(mon_e.due));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one entry until accepted or the bound expires; queue it on acceptance.
    task automatic push(input logic [31:0] pc, input logic [31:0] instr, input logic bd,
                        input logic [4:0] exc, input bit timed, input int max_cyc);
        bit   done = 1'b0;
        logic rdy;
        exp_t e;
        in_valid = 1'b1;
        in_pc    = pc;
        in_instr = instr;
        in_bd    = bd;
        in_exc   = exc;
        for (int i = 0; i < max_cyc && !done; i++) begin
            @(negedge clk);
            rdy = in_ready;
            step();
            if (rdy === 1'b1) begin
                done    = 1'b1;
                e.pc    = pc;
                e.instr = instr;
                e.bd    = bd;
                e.exc   = exc;
                e.due   = timed ? cyc : -1;
                exp_q.push_back(e);
            end
        end
        in_valid = 1'b0;
        chk("push_accept", {95'd0, done}, 96'd1);
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) step();
        reset = 1'b0;
        exp_q.delete();
    endtask

    task automatic pulse_ctl(input logic r, input logic f);
        req   = r;
        flush = f;
        step();
        req   = 1'b0;
        flush = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        do_reset(2);
        @(negedge clk);
        chk("rst_valid", {95'd0, out_valid}, 96'd0);
        chk("rst_pc", {64'd0, out_pc}, 96'd0);
        chk("rst_instr", {64'd0, out_instr}, 96'd0);
        chk("rst_bd_exc", {90'd0, out_bd, out_exc}, 96'd0);
        chk("rst_ready", {95'd0, in_ready}, 96'd1);

        // Streaming with out_ready high: 1-cycle latency, 1 entry/cycle
        step();
        out_ready = 1'b1;
        push(32'h3000, 32'h2401_0001, 1'b0, 5'd0, 1'b1, 1);
        push(32'h3004, 32'h2401_0002, 1'b1, 5'd2, 1'b1, 1);
        push(32'h3008, 32'h2401_0003, 1'b1, 5'd3, 1'b1, 1);
        step();
        @(negedge clk);
        chk("drain_valid", {95'd0, out_valid}, 96'd0);
        chk("drain_pc_kept", {64'd0, out_pc}, {64'd0, 32'h3008});
        chk("drain_bubble", {58'd0, out_instr, out_bd, out_exc}, 96'd0);

        // Back-pressure: fill both entries, third held upstream
        step();
        out_ready = 1'b0;
        push(32'h3000, 32'h2401_0011, 1'b0, 5'd1, 1'b0, 1);
        push(32'h3004, 32'h2401_0012, 1'b1, 5'd0, 1'b0, 1);
        fork
            push(32'h3008, 32'h2401_0013, 1'b0, 5'd4, 1'b0, 10);
            begin
                repeat (3) begin
                    @(negedge clk);
                    chk("full_ready", {95'd0, in_ready}, 96'd0);
                end
                step();
                out_ready = 1'b1;
            end
        join
        repeat (3) step();
        chk("bp_drained", 96'(exp_q.size()), 96'd0);

        // Exception request with TWO buffered and a same-cycle push
        out_ready = 1'b0;
        push(32'h3000, 32'h2401_0021, 1'b0, 5'd0, 1'b0, 1);
        push(32'h3004, 32'h2401_0022, 1'b0, 5'd0, 1'b0, 1);
        in_valid = 1'b1;
        in_pc    = 32'h300C;
        in_instr = 32'h2401_0023;
        pulse_ctl(1'b1, 1'b0);
        @(negedge clk);
        chk("req_valid", {95'd0, out_valid}, 96'd0);
        chk("req_pc", {64'd0, out_pc}, {64'd0, 32'h0000_4180});
        chk("req_bubble", {58'd0, out_instr, out_bd, out_exc}, 96'd0);
        chk("req_ready", {95'd0, in_ready}, 96'd1);
        step();
        out_ready = 1'b1;
        repeat (3) step();

        // req and flush together: req wins
        out_ready = 1'b0;
        push(32'h3010, 32'h2401_0031, 1'b0, 5'd0, 1'b0, 1);
        pulse_ctl(1'b1, 1'b1);
        @(negedge clk);
        chk("reqflush_pc", {64'd0, out_pc}, {64'd0, 32'h0000_4180});
        chk("reqflush_valid", {95'd0, out_valid}, 96'd0);

        // flush alone
        step();
        push(32'h3014, 32'h2401_0032, 1'b1, 5'd5, 1'b0, 1);
        @(negedge clk);
        chk("pre_flush_head", {26'd0, out_pc, out_instr, out_bd, out_exc},
            {26'd0, 32'h3014, 32'h2401_0032, 1'b1, 5'd5});
        step();
        pulse_ctl(1'b0, 1'b1);
        @(negedge clk);
        chk("flush_pc", {64'd0, out_pc}, 96'd0);
        chk("flush_bubble", {58'd0, out_instr, out_bd, out_exc}, 96'd0);
        chk("flush_valid", {95'd0, out_valid}, 96'd0);
        step();

`ifdef PIPE_STAGE_PERF_EN
        // Stall counter: 7 stalled cycles, unaffected by req, cleared by reset
        do_reset(1);
        out_ready = 1'b0;
        push(32'h3020, 32'h2401_0041, 1'b0, 5'd0, 1'b0, 1);
        repeat (7) step();
        chk("stall_7", {64'd0, stall_cnt}, 96'd7);
        out_ready = 1'b1;
        pulse_ctl(1'b1, 1'b0);
        repeat (2) step();
        chk("stall_after_req", {64'd0, stall_cnt}, 96'd7);
        do_reset(1);
        chk("stall_reset", {64'd0, stall_cnt}, 96'd0);
`endif

        // Reset mid-transfer loses both entries
        out_ready = 1'b0;
        push(32'h3030, 32'h2401_0051, 1'b1, 5'd1, 1'b0, 1);
        push(32'h3034, 32'h2401_0052, 1'b0, 5'd2, 1'b0, 1);
        do_reset(1);
        @(negedge clk);
        chk("midrst_state", {26'd0, out_valid, in_ready, out_pc, out_instr, out_bd, out_exc},
            {26'd0, 1'b0, 1'b1, 32'd0, 32'd0, 1'b0, 5'd0});
        step();
        out_ready = 1'b1;
        repeat (3) step();
        chk("final_drained", 96'(exp_q.size()), 96'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
